// File: rtl/lut_index_sequencer.sv
// Walks one layer's sparsity mask and streams each kept-weight index, lowest first, over valid/ready.
// First index two cycles after start; idx and idx_valid hold while idx_ready is low.
module lut_index_sequencer #(
  parameter int MAX_W  = 648,
  parameter int IDX_W  = 10,
  parameter int LAYERS = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       layer,
  input  logic             abort,
  output logic [3:0]       lut_addr,
  input  logic [MAX_W-1:0] mask_in,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [IDX_W-1:0] idx,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [IDX_W-1:0] nnz_count
);

  typedef enum logic [1:0] {IDLE, FETCH, SCAN, DONE} state_t;

  localparam logic [3:0]       LAST_LAYER = 4'(LAYERS);
  localparam logic [MAX_W-1:0] ONE_HOT0   = MAX_W'(1);

  state_t           state;
  logic [MAX_W-1:0] pending;
  logic [MAX_W-1:0] width_mask;
  logic [MAX_W-1:0] captured;
  logic [MAX_W-1:0] pending_clr;
  int               lay_w;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_W-1:0] v);
    lowest_set = '0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  // Mask width follows the latched layer, so the capture in FETCH trims bits beyond the layer.
  always_comb begin
    lay_w = 0;
    case (lut_addr)
      4'd1:             lay_w = 27;
      4'd2, 4'd3, 4'd4: lay_w = 324;
      4'd5, 4'd6, 4'd7: lay_w = 648;
      4'd8, 4'd9:       lay_w = 108;
      default:          lay_w = 0;
    endcase
    for (int i = 0; i < MAX_W; i++) width_mask[i] = (i < lay_w);
  end

  assign captured    = mask_in & width_mask;
  assign pending_clr = pending & ~(ONE_HOT0 << idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      lut_addr  <= '0;
      idx       <= '0;
      idx_valid <= 1'b0;
      nnz_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (layer != 4'd0 && layer <= LAST_LAYER) begin
              lut_addr  <= layer;
              nnz_count <= '0;
              busy      <= 1'b1;
              state     <= FETCH;
            end else begin
              err <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            pending <= '0;
          end else begin
            pending <= captured;
            if (captured != '0) begin
              idx       <= lowest_set(captured);
              idx_valid <= 1'b1;
              state     <= SCAN;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end
        SCAN: begin
          // Abort outranks a same-cycle handshake, which is therefore not counted.
          if (abort) begin
            state     <= IDLE;
            idx_valid <= 1'b0;
            busy      <= 1'b0;
            pending   <= '0;
          end else if (idx_ready) begin
            nnz_count <= nnz_count + IDX_W'(1);
            pending   <= pending_clr;
            if (pending_clr == '0) begin
              idx_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              idx <= lowest_set(pending_clr);
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
